// File: rtl/fp16_pkg.sv
// Shared types for the FP16 operand front end: operand class codes,
// field widths and the unpacked-operand / ordered-pair records.
package fp16_pkg;

  localparam int EXP_W  = 5;
  localparam int MANT_W = 10;
  localparam logic [EXP_W-1:0] EXP_MAX_VAL = 5'd31;

  typedef enum logic [2:0] {
    CLS_ZERO = 3'd0,
    CLS_SUB  = 3'd1,
    CLS_NORM = 3'd2,
    CLS_INF  = 3'd3,
    CLS_QNAN = 3'd4,
    CLS_SNAN = 3'd5
  } fp16_cls_e;

  typedef struct packed {
    logic              sign;
    logic [EXP_W-1:0]  exp;
    logic [MANT_W-1:0] mant;
    fp16_cls_e         cls;
  } fp16_op_t;

  typedef struct packed {
    logic              sign_a;
    logic              sign_b;
    logic [EXP_W-1:0]  exp_a;
    logic [EXP_W-1:0]  exp_b;
    logic [EXP_W-1:0]  exp_diff;
    logic [MANT_W-1:0] mant_a;
    logic [MANT_W-1:0] mant_b;
    logic              swapped;
    fp16_cls_e         cls_a;
    fp16_cls_e         cls_b;
    logic              exc_hint;
  } fp16_pair_t;

endpackage

// File: rtl/fp16_classify.sv
// Combinational binary16 unpacker and classifier.
// Build option FP16_OPSTAGE_FTZ_EN flushes subnormals to signed zero.
module fp16_classify
  import fp16_pkg::*;
(
  input  logic [15:0]       op_i,
  output logic              sign_o,
  output logic [EXP_W-1:0]  exp_o,
  output logic [EXP_W-1:0]  eff_exp_o,
  output logic [MANT_W-1:0] mant_o,
  output logic [2:0]        cls_o
);

  logic [EXP_W-1:0]  exp_raw;
  logic [MANT_W-1:0] mant_raw;
  fp16_cls_e         cls;

  assign sign_o   = op_i[15];
  assign exp_raw  = op_i[14:10];
  assign mant_raw = op_i[9:0];
  assign exp_o    = exp_raw;

  always_comb begin
    if (exp_raw == '0)
      cls = (mant_raw == '0) ? CLS_ZERO : CLS_SUB;
    else if (exp_raw != EXP_MAX_VAL)
      cls = CLS_NORM;
    else if (mant_raw == '0)
      cls = CLS_INF;
    else if (mant_raw[MANT_W-1])
      cls = CLS_QNAN;
    else
      cls = CLS_SNAN;
  end

`ifdef FP16_OPSTAGE_FTZ_EN
  // Flushed operands are true zeros, so their exponent stays 0 for alignment.
  assign mant_o    = (cls == CLS_SUB) ? '0 : mant_raw;
  assign cls_o     = (cls == CLS_SUB) ? CLS_ZERO : cls;
  assign eff_exp_o = exp_raw;
`else
  assign mant_o    = mant_raw;
  assign cls_o     = cls;
  assign eff_exp_o = (exp_raw == '0) ? EXP_W'(1) : exp_raw;
`endif

endmodule

// File: rtl/fp16_operand_stage.sv
// Two-stage operand front end for the FP16 adder: unpack/classify, then order by magnitude.
// Build option FP16_OPSTAGE_FTZ_EN enables subnormal flush-to-zero in stage 1.
module fp16_operand_stage
  import fp16_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [15:0]       in_a_i,
  input  logic [15:0]       in_b_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic              sign_a_o,
  output logic              sign_b_o,
  output logic [EXP_W-1:0]  exp_a_o,
  output logic [EXP_W-1:0]  exp_b_o,
  output logic [EXP_W-1:0]  exp_max_o,
  output logic [EXP_W-1:0]  exp_diff_o,
  output logic [MANT_W-1:0] mant_a_o,
  output logic [MANT_W-1:0] mant_b_o,
  output logic              swapped_o,
  output logic [2:0]        class_a_o,
  output logic [2:0]        class_b_o,
  output logic              exc_hint_o
);

  logic              sa, sb;
  logic [EXP_W-1:0]  ea, eb, fa, fb;
  logic [MANT_W-1:0] ma, mb;
  logic [2:0]        ca, cb;

  fp16_op_t          opa_d, opb_d, opa_q, opb_q;
  logic [EXP_W-1:0]  effa_d, effb_d, effa_q, effb_q;
  logic              v1_q, v2_q, adv1, adv2;

  fp16_op_t          hi, lo;
  logic [EXP_W-1:0]  hi_eff, lo_eff;
  logic              swap;
  fp16_pair_t        pair_d, pair_q;

  fp16_classify u_cls_a (
    .op_i(in_a_i), .sign_o(sa), .exp_o(ea), .eff_exp_o(fa), .mant_o(ma), .cls_o(ca)
  );

  fp16_classify u_cls_b (
    .op_i(in_b_i), .sign_o(sb), .exp_o(eb), .eff_exp_o(fb), .mant_o(mb), .cls_o(cb)
  );

  assign adv2       = ~v2_q | out_ready_i;
  assign adv1       = ~v1_q | adv2;
  assign in_ready_o = adv1;

  always_comb begin
    opa_d  = '{sign: sa, exp: ea, mant: ma, cls: fp16_cls_e'(ca)};
    opb_d  = '{sign: sb, exp: eb, mant: mb, cls: fp16_cls_e'(cb)};
    effa_d = fa;
    effb_d = fb;
  end

  // Ties keep the original order so equal magnitudes never report a swap.
  always_comb begin
    swap   = {opb_q.exp, opb_q.mant} > {opa_q.exp, opa_q.mant};
    hi     = swap ? opb_q : opa_q;
    lo     = swap ? opa_q : opb_q;
    hi_eff = swap ? effb_q : effa_q;
    lo_eff = swap ? effa_q : effb_q;

    pair_d          = '0;
    pair_d.sign_a   = hi.sign;
    pair_d.sign_b   = lo.sign;
    pair_d.exp_a    = hi.exp;
    pair_d.exp_b    = lo.exp;
    pair_d.exp_diff = hi_eff - lo_eff;
    pair_d.mant_a   = hi.mant;
    pair_d.mant_b   = lo.mant;
    pair_d.swapped  = swap;
    pair_d.cls_a    = hi.cls;
    pair_d.cls_b    = lo.cls;
    pair_d.exc_hint = (hi.cls >= CLS_INF) || (lo.cls >= CLS_INF);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      v1_q   <= 1'b0;
      v2_q   <= 1'b0;
      opa_q  <= '0;
      opb_q  <= '0;
      effa_q <= '0;
      effb_q <= '0;
      pair_q <= '0;
    end else begin
      if (adv1) begin
        v1_q <= in_valid_i;
        if (in_valid_i) begin
          opa_q  <= opa_d;
          opb_q  <= opb_d;
          effa_q <= effa_d;
          effb_q <= effb_d;
        end
      end
      if (adv2) begin
        v2_q <= v1_q;
        if (v1_q) pair_q <= pair_d;
      end
    end
  end

  assign out_valid_o = v2_q;
  assign sign_a_o    = pair_q.sign_a;
  assign sign_b_o    = pair_q.sign_b;
  assign exp_a_o     = pair_q.exp_a;
  assign exp_b_o     = pair_q.exp_b;
  assign exp_max_o   = pair_q.exp_a;
  assign exp_diff_o  = pair_q.exp_diff;
  assign mant_a_o    = pair_q.mant_a;
  assign mant_b_o    = pair_q.mant_b;
  assign swapped_o   = pair_q.swapped;
  assign class_a_o   = pair_q.cls_a;
  assign class_b_o   = pair_q.cls_b;
  assign exc_hint_o  = pair_q.exc_hint;

endmodule

// File: tb/tb_fp16_operand_stage.sv
// Directed bench for fp16_operand_stage: classification, ordering, backpressure and reset.
// Expectations follow FP16_OPSTAGE_FTZ_EN when the bench is built with it.
module tb_fp16_operand_stage;

  logic        clk = 1'b0;
  logic        rstN, inValid, inReady, outValid, outReady;
  logic [15:0] inA, inB;
  logic        signA, signB, swapped, excHint;
  logic [4:0]  expA, expB, expMax, expDiff;
  logic [9:0]  mantA, mantB;
  logic [2:0]  classA, classB;

  int checkCount = 0;
  int failCount  = 0;

  fp16_operand_stage dut (
    .clk_i(clk), .rst_ni(rstN), .in_valid_i(inValid), .in_ready_o(inReady),
    .in_a_i(inA), .in_b_i(inB), .out_valid_o(outValid), .out_ready_i(outReady),
    .sign_a_o(signA), .sign_b_o(signB), .exp_a_o(expA), .exp_b_o(expB),
    .exp_max_o(expMax), .exp_diff_o(expDiff), .mant_a_o(mantA), .mant_b_o(mantB),
    .swapped_o(swapped), .class_a_o(classA), .class_b_o(classB), .exc_hint_o(excHint)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
    checkCount++;
    if (got !== want) begin
      failCount++;
      $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, want);
    end
  endtask

  task automatic checkVec(input string tag, input logic sw, input logic sa, input logic sb,
                          input logic [4:0] ea, input logic [4:0] eb, input logic [4:0] ed,
                          input logic [9:0] ma, input logic [9:0] mb,
                          input logic [2:0] ca, input logic [2:0] cb, input logic ex);
    checkOutput({tag, "_swapped"}, 32'(swapped), 32'(sw));
    checkOutput({tag, "_signA"},   32'(signA),   32'(sa));
    checkOutput({tag, "_signB"},   32'(signB),   32'(sb));
    checkOutput({tag, "_expA"},    32'(expA),    32'(ea));
    checkOutput({tag, "_expB"},    32'(expB),    32'(eb));
    checkOutput({tag, "_expMax"},  32'(expMax),  32'(ea));
    checkOutput({tag, "_expDiff"}, 32'(expDiff), 32'(ed));
    checkOutput({tag, "_mantA"},   32'(mantA),   32'(ma));
    checkOutput({tag, "_mantB"},   32'(mantB),   32'(mb));
    checkOutput({tag, "_classA"},  32'(classA),  32'(ca));
    checkOutput({tag, "_classB"},  32'(classB),  32'(cb));
    checkOutput({tag, "_excHint"}, 32'(excHint), 32'(ex));
  endtask

  // One pair into an empty pipe; verifies it appears after the second edge, not the first.
  task automatic applyStimulus(input string tag, input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    inValid  = 1'b1;
    inA      = a;
    inB      = b;
    outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput({tag, "_early"}, 32'(outValid), 32'd0);
    @(negedge clk);
    checkOutput({tag, "_valid"}, 32'(outValid), 32'd1);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rstN = 1'b0; inValid = 1'b0; outReady = 1'b1; inA = '0; inB = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_outValid", 32'(outValid), 32'd0);
    checkOutput("rst_inReady",  32'(inReady),  32'd1);
    checkOutput("rst_classA",   32'(classA),   32'd0);
    checkOutput("rst_classB",   32'(classB),   32'd0);
    rstN = 1'b1;

    applyStimulus("v1", 16'h3C00, 16'h4000);
    checkVec("v1", 1, 0, 0, 5'd16, 5'd15, 5'd1, 10'h0, 10'h0, 3'd2, 3'd2, 0);

    applyStimulus("v2", 16'h0001, 16'h0400);
`ifdef FP16_OPSTAGE_FTZ_EN
    checkVec("v2", 1, 0, 0, 5'd1, 5'd0, 5'd1, 10'h0, 10'h0, 3'd2, 3'd0, 0);
`else
    checkVec("v2", 1, 0, 0, 5'd1, 5'd0, 5'd0, 10'h0, 10'h1, 3'd2, 3'd1, 0);
`endif

    applyStimulus("v3", 16'h7D00, 16'hFC00);
    checkVec("v3", 0, 0, 1, 5'd31, 5'd31, 5'd0, 10'h100, 10'h0, 3'd5, 3'd3, 1);

    applyStimulus("v4", 16'h7E00, 16'h3C00);
    checkVec("v4", 0, 0, 0, 5'd31, 5'd15, 5'd16, 10'h200, 10'h0, 3'd4, 3'd2, 1);

    applyStimulus("tie", 16'hC200, 16'h4200);
    checkVec("tie", 0, 1, 0, 5'd16, 5'd16, 5'd0, 10'h200, 10'h200, 3'd2, 3'd2, 0);

    // Backpressure: three pairs against a stalled sink, then release.
    @(negedge clk);
    outReady = 1'b0; inValid = 1'b1; inA = 16'h3C00; inB = 16'h4000;
    @(negedge clk);
    checkOutput("bp_ready1", 32'(inReady), 32'd1);
    inA = 16'h4400; inB = 16'h0000;
    @(negedge clk);
    checkOutput("bp_valid2", 32'(outValid), 32'd1);
    checkOutput("bp_ready2", 32'(inReady),  32'd0);
    checkOutput("bp_p1_expA", 32'(expA), 32'd16);
    inA = 16'h0000; inB = 16'h4800;
    @(negedge clk);
    checkOutput("bp_hold_valid",   32'(outValid), 32'd1);
    checkOutput("bp_hold_ready",   32'(inReady),  32'd0);
    checkOutput("bp_hold_expA",    32'(expA),     32'd16);
    checkOutput("bp_hold_swapped", 32'(swapped),  32'd1);
    outReady = 1'b1;
    @(negedge clk);
    inValid = 1'b0;
    checkOutput("bp_p2_valid",   32'(outValid), 32'd1);
    checkOutput("bp_p2_expA",    32'(expA),     32'd17);
    checkOutput("bp_p2_swapped", 32'(swapped),  32'd0);
    @(negedge clk);
    checkOutput("bp_p3_valid",   32'(outValid), 32'd1);
    checkOutput("bp_p3_expA",    32'(expA),     32'd18);
    checkOutput("bp_p3_swapped", 32'(swapped),  32'd1);
    @(negedge clk);
    checkOutput("bp_drained", 32'(outValid), 32'd0);

    // Reset with both stages holding non-zero pairs.
    outReady = 1'b0; inValid = 1'b1; inA = 16'hFC00; inB = 16'h7E00;
    @(negedge clk);
    @(negedge clk);
    checkOutput("rf_full_valid", 32'(outValid), 32'd1);
    rstN = 1'b0; inValid = 1'b0;
    @(negedge clk);
    checkOutput("rf_outValid", 32'(outValid), 32'd0);
    checkOutput("rf_inReady",  32'(inReady),  32'd1);
    checkVec("rf", 0, 0, 0, 5'd0, 5'd0, 5'd0, 10'h0, 10'h0, 3'd0, 3'd0, 0);
    rstN = 1'b1;

    applyStimulus("post", 16'h3C00, 16'h4000);
    checkOutput("post_expA",    32'(expA),    32'd16);
    checkOutput("post_swapped", 32'(swapped), 32'd1);
    @(negedge clk);
    checkOutput("post_drained", 32'(outValid), 32'd0);

    $display("test done: total=%0d bad=%0d", checkCount, failCount);
    $finish;
  end

endmodule
